// File: rtl/conv_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Optional feature: CONV_SIGNED_EN selects two's-complement input handling.
package conv_pkg;

    localparam int N_BITS = 8;
    localparam int N_DIG  = 3;
    localparam int ITER   = 8;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

    // Value that enters the shift register: raw input, or its absolute value
    // in the signed build (-128 folds to 128 as an 8-bit unsigned quantity).
    function automatic logic [N_BITS-1:0] magnitud(input logic [N_BITS-1:0] b);
`ifdef CONV_SIGNED_EN
        return b[N_BITS-1] ? (~b + 1'b1) : b;
`else
        return b;
`endif
    endfunction

endpackage

// File: rtl/conv_bcd_if.sv
// Handshake and data bundle between the multiplier side and the converter.
interface conv_bcd_if;
    import conv_pkg::*;

    logic              start;
    logic [N_BITS-1:0] binario;
    logic              signo;
    logic [3:0]        centenas;
    logic [3:0]        decenas;
    logic [3:0]        unidades;
    logic              fin;

    modport master (
        output start, binario,
        input  signo, centenas, decenas, unidades, fin
    );

    modport slave (
        input  start, binario,
        output signo, centenas, decenas, unidades, fin
    );

endinterface

// File: rtl/conv_bcd_ajuste3.sv
// Combinational BCD digit corrector: adds 3 to any digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module ajuste3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/conv_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3 over 8 iterations).
// Optional feature: define CONV_SIGNED_EN to treat binario as two's complement
// and report its sign on signo; otherwise signo is tied low.
module conv_bcd
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    conv_bcd_if.slave  bus
);

    estado_t             estado_q, estado_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                start_q;
    logic [4*N_DIG-1:0]  scr_q, scr_d;
    logic [N_BITS-1:0]   mag_q, mag_d;
    logic [3:0]          cen_q, cen_d;
    logic [3:0]          dec_q, dec_d;
    logic [3:0]          uni_q, uni_d;
    logic                fin_q, fin_d;
    logic                disparo;
    logic [4*N_DIG-1:0]  adj;
`ifdef CONV_SIGNED_EN
    logic                sgn_q, sgn_d;
    logic                signo_q, signo_d;
`endif

    assign disparo = bus.start & ~start_q;

    ajuste3 u_adj_cen (.d_i(scr_q[11:8]), .d_o(adj[11:8]));
    ajuste3 u_adj_dec (.d_i(scr_q[7:4]),  .d_o(adj[7:4]));
    ajuste3 u_adj_uni (.d_i(scr_q[3:0]),  .d_o(adj[3:0]));

    // Next-state, datapath and Moore output decode.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        scr_d    = scr_q;
        mag_d    = mag_q;
        cen_d    = cen_q;
        dec_d    = dec_q;
        uni_d    = uni_q;
`ifdef CONV_SIGNED_EN
        sgn_d    = sgn_q;
        signo_d  = signo_q;
`endif
        case (estado_q)
            REPOSO, FIN: begin
                if (disparo) begin
                    mag_d    = magnitud(bus.binario);
`ifdef CONV_SIGNED_EN
                    sgn_d    = bus.binario[N_BITS-1];
`endif
                    scr_d    = '0;
                    cnt_d    = '0;
                    estado_d = DESPLAZA;
                end
            end
            DESPLAZA: begin
                // Correct digits first, then shift the combined {digits, magnitude}.
                {scr_d, mag_d} = {adj[4*N_DIG-2:0], mag_q, 1'b0};
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'(ITER - 1)) begin
                    cen_d    = scr_d[11:8];
                    dec_d    = scr_d[7:4];
                    uni_d    = scr_d[3:0];
`ifdef CONV_SIGNED_EN
                    signo_d  = sgn_q;
`endif
                    estado_d = FIN;
                end
            end
            default: estado_d = REPOSO;
        endcase
        fin_d = (estado_d == FIN);
    end

    // State and data registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            scr_q    <= '0;
            mag_q    <= '0;
            cen_q    <= '0;
            dec_q    <= '0;
            uni_q    <= '0;
            fin_q    <= 1'b0;
`ifdef CONV_SIGNED_EN
            sgn_q    <= 1'b0;
            signo_q  <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            start_q  <= bus.start;
            scr_q    <= scr_d;
            mag_q    <= mag_d;
            cen_q    <= cen_d;
            dec_q    <= dec_d;
            uni_q    <= uni_d;
            fin_q    <= fin_d;
`ifdef CONV_SIGNED_EN
            sgn_q    <= sgn_d;
            signo_q  <= signo_d;
`endif
        end
    end

    assign bus.centenas = cen_q;
    assign bus.decenas  = dec_q;
    assign bus.unidades = uni_q;
    assign bus.fin      = fin_q;
`ifdef CONV_SIGNED_EN
    assign bus.signo    = signo_q;
`else
    assign bus.signo    = 1'b0;
`endif

endmodule

// File: tb/tb_conv_bcd.sv
// Directed self-checking bench for conv_bcd (expectations follow CONV_SIGNED_EN).
module tb_conv_bcd;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    conv_bcd_if bus ();

    conv_bcd dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {signo, centenas, decenas, unidades, fin}
    logic [13:0] obs;
    assign obs = {bus.signo, bus.centenas, bus.decenas, bus.unidades, bus.fin};

`ifdef CONV_SIGNED_EN
    localparam logic [12:0] EXP_C8 = {1'b1, 12'h056};
    localparam logic [12:0] EXP_80 = {1'b1, 12'h128};
`else
    localparam logic [12:0] EXP_C8 = {1'b0, 12'h200};
    localparam logic [12:0] EXP_80 = {1'b0, 12'h128};
`endif

    // Called on a falling edge; returns on the falling edge after E0.
    task automatic trig(input logic [7:0] b);
        bus.binario = b;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.binario = 8'h00;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.binario = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== 14'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs, 14'h0);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max();
        trig(8'hFF);
        repeat (7) @(negedge clk);
        total++;
        if (obs !== 14'h0) begin
            bad++;
            $display("FAIL max_before_E8 got=%h want=%h", obs, 14'h0);
        end
        @(negedge clk);
        total++;
        if (obs !== {1'b0, 12'h255, 1'b1}) begin
            bad++;
            $display("FAIL max_E8 got=%h want=%h", obs, {1'b0, 12'h255, 1'b1});
        end
    endtask

    task automatic test_hold_start();
        @(negedge clk);
        bus.binario = 8'h2A;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.binario = 8'h11;
        repeat (8) @(negedge clk);
        total++;
        if (obs !== {1'b0, 12'h042, 1'b1}) begin
            bad++;
            $display("FAIL hold_first got=%h want=%h", obs, {1'b0, 12'h042, 1'b1});
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            total++;
            if (obs !== {1'b0, 12'h042, 1'b1}) begin
                bad++;
                $display("FAIL hold_no_retrigger cyc=%0d got=%h want=%h", i, obs, {1'b0, 12'h042, 1'b1});
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        trig(8'h11);
        repeat (8) @(negedge clk);
        total++;
        if (obs !== {1'b0, 12'h017, 1'b1}) begin
            bad++;
            $display("FAIL hold_rearm got=%h want=%h", obs, {1'b0, 12'h017, 1'b1});
        end
    endtask

    task automatic test_ignore_retrigger();
        trig(8'h63);
        for (int i = 1; i < 8; i++) begin
            total++;
            if (obs !== {1'b0, 12'h017, 1'b0}) begin
                bad++;
                $display("FAIL busy_hold E%0d got=%h want=%h", i, obs, {1'b0, 12'h017, 1'b0});
            end
            if (i == 2) begin
                bus.binario = 8'h05;
                bus.start   = 1'b1;
            end else if (i == 3) begin
                bus.start   = 1'b0;
                bus.binario = 8'h00;
            end
            @(negedge clk);
        end
        total++;
        if (obs !== {1'b0, 12'h017, 1'b0}) begin
            bad++;
            $display("FAIL busy_hold E7 got=%h want=%h", obs, {1'b0, 12'h017, 1'b0});
        end
        @(negedge clk);
        total++;
        if (obs !== {1'b0, 12'h099, 1'b1}) begin
            bad++;
            $display("FAIL ignore_result got=%h want=%h", obs, {1'b0, 12'h099, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        trig(8'h7B);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 14'h0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=%h", obs, 14'h0);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (obs !== 14'h0) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", obs, 14'h0);
        end
        trig(8'hC8);
        repeat (8) @(negedge clk);
        total++;
        if (obs !== {EXP_C8, 1'b1}) begin
            bad++;
            $display("FAIL after_reset_c8 got=%h want=%h", obs, {EXP_C8, 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        // Each trigger lands on the edge right after the previous FIN cycle begins.
        trig(8'h40);
        repeat (8) @(negedge clk);
        total++;
        if (obs !== {1'b0, 12'h064, 1'b1}) begin
            bad++;
            $display("FAIL b2b_40 got=%h want=%h", obs, {1'b0, 12'h064, 1'b1});
        end
        trig(8'h80);
        total++;
        if (obs !== {1'b0, 12'h064, 1'b0}) begin
            bad++;
            $display("FAIL b2b_fin_drop got=%h want=%h", obs, {1'b0, 12'h064, 1'b0});
        end
        repeat (8) @(negedge clk);
        total++;
        if (obs !== {EXP_80, 1'b1}) begin
            bad++;
            $display("FAIL b2b_80 got=%h want=%h", obs, {EXP_80, 1'b1});
        end
        trig(8'h00);
        repeat (8) @(negedge clk);
        total++;
        if (obs !== {1'b0, 12'h000, 1'b1}) begin
            bad++;
            $display("FAIL b2b_00 got=%h want=%h", obs, {1'b0, 12'h000, 1'b1});
        end
        trig(8'hC8);
        repeat (8) @(negedge clk);
        total++;
        if (obs !== {EXP_C8, 1'b1}) begin
            bad++;
            $display("FAIL b2b_c8 got=%h want=%h", obs, {EXP_C8, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_hold_start();
        test_ignore_retrigger();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
